// File: rtl/data_mem_responder.sv
// Fixed-latency data-memory responder below the MEM stage: stalls while a request is pending,
// returns the pre-write word in RESP and commits byte-masked stores. LL_SC_LINK_EN enables the LL/SC link register.
module data_mem_responder #(
    parameter int ADDR_W = 10,
    parameter int LAT    = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] data_address_2DM,
    input  logic [31:0] data_write_2DM,
    input  logic [1:0]  data_write_size_2DM,
    input  logic        MemRead_2DM,
    input  logic        MemWrite_2DM,
    input  logic        ll_2DM,
    input  logic        sc_2DM,
    output logic [31:0] data_read_fDM,
    output logic        MEM_stall,
    output logic        sc_success_fDM
);

    // state   | meaning
    // IDLE    | waiting for a request; accepts and stalls in the same cycle
    // WAIT    | backing SRAM busy; wait counter runs down to terminal count 1
    // RESP    | response word presented; store committed at the end of this cycle
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int DEPTH = 2 ** ADDR_W;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              wr_q, wr_d;
    logic              sc_q, sc_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [31:0]       mem_q [DEPTH];

    logic [3:0]        lane_en;
    logic [2:0]        nbytes;
    logic [2:0]        lane_lo;
    logic [2:0]        lane_hi;
    logic              sc_ok;
    logic              store_commit;
    logic              req;
    logic              unused_addr_bits;

`ifdef LL_SC_LINK_EN
    logic              ll_q, ll_d;
    logic              link_valid_q, link_valid_d;
    logic [ADDR_W-1:0] link_word_q, link_word_d;
`endif

    assign unused_addr_bits = ^{data_address_2DM[31:ADDR_W+2], ll_2DM};
    assign req = MemRead_2DM | MemWrite_2DM;

    // Lanes beyond byte 3 simply fall outside the mask; no wrap into the next word.
    always_comb begin
        lane_en = '0;
        nbytes  = (size_q == 2'd0) ? 3'd4 : {1'b0, size_q};
        lane_lo = {1'b0, lane_q};
        lane_hi = lane_lo + nbytes;
        for (int i = 0; i < 4; i++) begin
            lane_en[i] = (3'(i) >= lane_lo) && (3'(i) < lane_hi);
        end
    end

`ifdef LL_SC_LINK_EN
    assign sc_ok = !sc_q || (link_valid_q && (link_word_q == word_q));
`else
    assign sc_ok = 1'b1;
`endif

    assign store_commit   = (state_q == ST_RESP) && wr_q && sc_ok;
    assign sc_success_fDM = (state_q == ST_RESP) && wr_q && sc_q && sc_ok;
    assign data_read_fDM  = rdata_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        word_d    = word_q;
        lane_d    = lane_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        wr_d      = wr_q;
        sc_d      = sc_q;
        rdata_d   = rdata_q;
        MEM_stall = 1'b0;
`ifdef LL_SC_LINK_EN
        ll_d         = ll_q;
        link_valid_d = link_valid_q;
        link_word_d  = link_word_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    MEM_stall = 1'b1;
                    state_d   = ST_WAIT;
                    cnt_d     = 4'(LAT);
                    word_d    = data_address_2DM[ADDR_W+1:2];
                    lane_d    = data_address_2DM[1:0];
                    wdata_d   = data_write_2DM;
                    size_d    = data_write_size_2DM;
                    wr_d      = MemWrite_2DM;
                    sc_d      = MemWrite_2DM & sc_2DM;
`ifdef LL_SC_LINK_EN
                    ll_d      = MemRead_2DM & ll_2DM & ~MemWrite_2DM;
`endif
                end
            end
            ST_WAIT: begin
                MEM_stall = 1'b1;
                cnt_d     = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_RESP;
                    // Captured before this request's own store commits, so RESP shows the old word.
                    rdata_d = mem_q[word_q];
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
`ifdef LL_SC_LINK_EN
                if (wr_q && sc_q) begin
                    link_valid_d = 1'b0;
                end else if (store_commit && (link_word_q == word_q)) begin
                    link_valid_d = 1'b0;
                end else if (ll_q) begin
                    link_valid_d = 1'b1;
                    link_word_d  = word_q;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            word_q  <= '0;
            lane_q  <= 2'd0;
            wdata_q <= 32'd0;
            size_q  <= 2'd0;
            wr_q    <= 1'b0;
            sc_q    <= 1'b0;
            rdata_q <= 32'd0;
`ifdef LL_SC_LINK_EN
            ll_q         <= 1'b0;
            link_valid_q <= 1'b0;
            link_word_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            lane_q  <= lane_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            wr_q    <= wr_d;
            sc_q    <= sc_d;
            rdata_q <= rdata_d;
`ifdef LL_SC_LINK_EN
            ll_q         <= ll_d;
            link_valid_q <= link_valid_d;
            link_word_q  <= link_word_d;
`endif
        end
    end

    // Array is deliberately outside the reset domain; a reset in RESP suppresses the write.
    always_ff @(posedge CLK) begin
        if (!RESET && store_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem_q[word_q][31-8*i -: 8] <= wdata_q[31-8*i -: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: transaction-level memory/link model drives
// per-cycle expectations checked every negedge, plus directed literal checks.
module tb_data_mem_responder;

    localparam int ADDR_W = 10;
    localparam int LAT    = 2;
    localparam int DEPTH  = 1 << ADDR_W;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] data_address_2DM;
    logic [31:0] data_write_2DM;
    logic [1:0]  data_write_size_2DM;
    logic        MemRead_2DM;
    logic        MemWrite_2DM;
    logic        ll_2DM;
    logic        sc_2DM;
    logic [31:0] data_read_fDM;
    logic        MEM_stall;
    logic        sc_success_fDM;

    data_mem_responder #(.ADDR_W(ADDR_W), .LAT(LAT)) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .data_address_2DM   (data_address_2DM),
        .data_write_2DM     (data_write_2DM),
        .data_write_size_2DM(data_write_size_2DM),
        .MemRead_2DM        (MemRead_2DM),
        .MemWrite_2DM       (MemWrite_2DM),
        .ll_2DM             (ll_2DM),
        .sc_2DM             (sc_2DM),
        .data_read_fDM      (data_read_fDM),
        .MEM_stall          (MEM_stall),
        .sc_success_fDM     (sc_success_fDM)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    logic        check_en  = 1'b0;
    logic        exp_stall = 1'b0;
    logic        exp_sc    = 1'b0;
    logic        exp_known = 1'b1;
    logic [31:0] exp_data  = 32'd0;

    logic [31:0] mdl_mem   [DEPTH];
    bit          mdl_known [DEPTH];
    bit          link_valid = 1'b0;
    int          link_word  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (check_en) begin
            check("stall", {31'd0, MEM_stall}, {31'd0, exp_stall});
            check("sc_success", {31'd0, sc_success_fDM}, {31'd0, exp_sc});
            if (exp_known) check("data_read", data_read_fDM, exp_data);
        end
    end

    task automatic scramble_inputs();
        data_address_2DM    = $urandom;
        data_write_2DM      = $urandom;
        data_write_size_2DM = 2'($urandom_range(0, 3));
        MemRead_2DM         = 1'($urandom_range(0, 1));
        MemWrite_2DM        = 1'($urandom_range(0, 1));
        ll_2DM              = 1'($urandom_range(0, 1));
        sc_2DM              = 1'($urandom_range(0, 1));
    endtask

    task automatic idle_inputs();
        scramble_inputs();
        MemRead_2DM  = 1'b0;
        MemWrite_2DM = 1'b0;
    endtask

    // Starts at posedge+1 of an idle cycle, ends at posedge+1 of the following idle cycle.
    task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                          input logic rd, input logic wr, input logic ll, input logic sc,
                          output logic [31:0] rdata, output logic sc_res, output int nstall);
        int          w;
        int          lane;
        int          n;
        bit          is_sc;
        bit          is_ll;
        bit          succ;
        bit          commit;
        bit          old_known;
        logic [31:0] old;
        logic [31:0] newv;

        w         = int'((a >> 2) & 32'(DEPTH - 1));
        lane      = int'(a[1:0]);
        n         = (sz == 2'd0) ? 4 : int'(sz);
        is_sc     = wr && sc;
        is_ll     = rd && ll && !wr;
        old       = mdl_mem[w];
        old_known = mdl_known[w];
`ifdef LL_SC_LINK_EN
        succ   = is_sc && link_valid && (link_word == w);
        commit = wr && (!is_sc || succ);
`else
        succ   = is_sc;
        commit = wr;
`endif
        newv = old;
        for (int b = 0; b < 4; b++) begin
            if (b >= lane && b < lane + n) newv[31-8*b -: 8] = d[31-8*b -: 8];
        end

        data_address_2DM    = a;
        data_write_2DM      = d;
        data_write_size_2DM = sz;
        MemRead_2DM         = rd;
        MemWrite_2DM        = wr;
        ll_2DM              = ll;
        sc_2DM              = sc;
        exp_stall           = 1'b1;
        exp_sc              = 1'b0;
        nstall              = 0;
        @(negedge CLK);
        if (MEM_stall) nstall++;
        for (int c = 1; c <= LAT; c++) begin
            @(posedge CLK); #1;
            scramble_inputs();
            exp_stall = 1'b1;
            @(negedge CLK);
            if (MEM_stall) nstall++;
        end
        @(posedge CLK); #1;
        scramble_inputs();
        exp_stall = 1'b0;
        exp_data  = old;
        exp_known = old_known;
        exp_sc    = succ;
        @(negedge CLK);
        rdata  = data_read_fDM;
        sc_res = sc_success_fDM;
        if (MEM_stall) nstall++;
        @(posedge CLK); #1;
        idle_inputs();
        exp_sc = 1'b0;
        if (commit) begin
            mdl_known[w] = old_known || (lane == 0 && n == 4);
            mdl_mem[w]   = newv;
        end
`ifdef LL_SC_LINK_EN
        if (is_sc) link_valid = 1'b0;
        else if (commit && link_word == w) link_valid = 1'b0;
        else if (is_ll) begin
            link_valid = 1'b1;
            link_word  = w;
        end
`endif
    endtask

    task automatic idle_cycle();
        idle_inputs();
        exp_stall = 1'b0;
        @(posedge CLK); #1;
    endtask

    // Full store that is aborted by a two-cycle reset in its first WAIT cycle.
    task automatic reset_mid_wait(input logic [31:0] a, input logic [31:0] d);
        data_address_2DM    = a;
        data_write_2DM      = d;
        data_write_size_2DM = 2'd0;
        MemRead_2DM         = 1'b0;
        MemWrite_2DM        = 1'b1;
        ll_2DM              = 1'b0;
        sc_2DM              = 1'b0;
        exp_stall           = 1'b1;
        exp_sc              = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b1;
        idle_inputs();
        exp_stall = 1'b1;
        @(posedge CLK); #1;
        exp_stall = 1'b0;
        exp_data  = 32'd0;
        exp_known = 1'b1;
        exp_sc    = 1'b0;
        @(negedge CLK);
        check("rst_wait_data", data_read_fDM, 32'd0);
        check("rst_wait_stall", {31'd0, MEM_stall}, 32'd0);
        @(posedge CLK); #1;
        RESET      = 1'b0;
        link_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        s;
        int          ns;

        for (int i = 0; i < DEPTH; i++) begin
            mdl_mem[i]   = 32'd0;
            mdl_known[i] = 1'b0;
        end
        RESET = 1'b1;
        idle_inputs();
        repeat (2) @(posedge CLK);
        #1;
        check_en = 1'b1;
        @(negedge CLK);
        check("reset_data", data_read_fDM, 32'd0);
        check("reset_stall", {31'd0, MEM_stall}, 32'd0);
        check("reset_sc", {31'd0, sc_success_fDM}, 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;

        for (int i = 0; i < 32; i++) begin
            do_req(32'(i * 4), $urandom, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, r, s, ns);
        end

        do_req(32'h20, 32'h11223344, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, r, s, ns);
        do_req(32'h22, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, r, s, ns);
        check("ld_0x22_data", r, 32'h11223344);
        check("ld_stall_cycles", 32'(ns), 32'd3);

        do_req(32'h23, 32'h000000AA, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, r, s, ns);
        do_req(32'h20, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, r, s, ns);
        check("byte_store_lane3", r, 32'h112233AA);
        do_req(32'h22, 32'hCCDDEEFF, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, r, s, ns);
        do_req(32'h20, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, r, s, ns);
        check("size3_lane2_no_wrap", r, 32'h1122EEFF);

        do_req(32'h30, 32'h5, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, r, s, ns);
        do_req(32'h30, 32'h7, 2'd0, 1'b1, 1'b1, 1'b0, 1'b0, r, s, ns);
        check("rd_wr_old_word", r, 32'h5);
        do_req(32'h30, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, r, s, ns);
        check("rd_wr_new_word", r, 32'h7);

        do_req(32'h10, 32'h0BADF00D, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, r, s, ns);
        do_req(32'h20, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, r, s, ns);
        reset_mid_wait(32'h10, 32'hDEADBEEF);
        do_req(32'h10, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, r, s, ns);
        check("rst_no_write", r, 32'h0BADF00D);

`ifdef LL_SC_LINK_EN
        do_req(32'h40, 32'h0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, r, s, ns);
        do_req(32'h40, 32'h99, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, r, s, ns);
        check("sc_linked_success", {31'd0, s}, 32'd1);
        do_req(32'h40, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, r, s, ns);
        check("sc_linked_word", r, 32'h99);
        do_req(32'h40, 32'h0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b0, r, s, ns);
        do_req(32'h40, 32'h55, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, r, s, ns);
        do_req(32'h40, 32'h77, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, r, s, ns);
        check("sc_broken_fail", {31'd0, s}, 32'd0);
        do_req(32'h40, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, r, s, ns);
        check("sc_broken_word", r, 32'h55);
`else
        do_req(32'h40, 32'h99, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, r, s, ns);
        check("sc_plain_success", {31'd0, s}, 32'd1);
        do_req(32'h40, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, r, s, ns);
        check("sc_plain_word", r, 32'h99);
`endif

        do_req(32'h1008, 32'h12345678, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, r, s, ns);
        do_req(32'h8, 32'h0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, r, s, ns);
        check("alias_0x1008", r, 32'h12345678);

        for (int k = 0; k < 400; k++) begin
            logic [31:0] a;
            logic        rd;
            logic        wr;
            a  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            rd = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            if (!rd && !wr) rd = 1'b1;
            do_req(a, $urandom, 2'($urandom_range(0, 3)), rd, wr,
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r, s, ns);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        repeat (2) idle_cycle();
        check_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
